// File: rtl/axil_spi_arb_pkg.sv
// Shared state encoding, AXI response codes and sizing helper for the axi_spi register-port arbiter.
package axil_spi_arb_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR_REQ  = 3'd1,
        WR_RESP = 3'd2,
        RD_REQ  = 3'd3,
        RD_DATA = 3'd4,
        RESP    = 3'd5
    } arb_state_e;

    localparam logic [1:0] RESP_OKAY        = 2'b00;
    localparam logic [1:0] RESP_EXOKAY      = 2'b01;
    localparam logic [1:0] RESP_SLVERR      = 2'b10;
    localparam logic [1:0] RESP_DECERR      = 2'b11;
    localparam logic [2:0] AXI_PROT_DEFAULT = 3'b000;

    // Index width that stays legal (1 bit) when there is only one requester.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/axil_rr_pick.sv
// Combinational requester selector: round-robin after last_grant, or lowest-index-first
// when built with AXIL_SPI_ARB_FIXED_PRIO_EN.
module axil_rr_pick
    import axil_spi_arb_pkg::*;
#(
    parameter  int NUM_REQ = 4,
    localparam int IDX_W   = idx_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   last_grant,
    output logic [NUM_REQ-1:0] grant_oh,
    output logic [IDX_W-1:0]   grant_idx,
    output logic               grant_any,
    output logic               rr_mode
);

`ifdef AXIL_SPI_ARB_FIXED_PRIO_EN
    logic unused_last_s;
    assign unused_last_s = ^last_grant;
    assign rr_mode       = 1'b0;

    // Lowest requesting index wins.
    always_comb begin
        grant_oh  = '0;
        grant_idx = '0;
        grant_any = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!grant_any && req[k]) begin
                grant_any = 1'b1;
                grant_idx = IDX_W'(k);
            end else begin
                grant_any = grant_any;
            end
        end
        grant_oh[grant_idx] = grant_any;
    end
`else
    assign rr_mode = 1'b1;

    // Search upward from last_grant+1, wrapping, so the last winner is tried last.
    always_comb begin
        grant_oh  = '0;
        grant_idx = '0;
        grant_any = 1'b0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            if (!grant_any && req[(int'(last_grant) + k) % NUM_REQ]) begin
                grant_any = 1'b1;
                grant_idx = IDX_W'((int'(last_grant) + k) % NUM_REQ);
            end else begin
                grant_any = grant_any;
            end
        end
        grant_oh[grant_idx] = grant_any;
    end
`endif

endmodule

// File: rtl/axil_spi_reg_arbiter.sv
// Shares one AXI4-Lite master port to the axi_spi register bank between NUM_REQ requesters,
// one transaction at a time. Build macro AXIL_SPI_ARB_FIXED_PRIO_EN selects fixed priority.
module axil_spi_reg_arbiter
    import axil_spi_arb_pkg::*;
#(
    parameter  int NUM_REQ    = 4,
    parameter  int ADDR_WIDTH = 32,
    parameter  int DATA_WIDTH = 32,
    localparam int IDX_W      = idx_width(NUM_REQ)
) (
    input  logic                          ACLK,
    input  logic                          ARESETN,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ-1:0]            req_we,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic [NUM_REQ-1:0]            rsp_valid,
    output logic [DATA_WIDTH-1:0]         rsp_rdata,
    output logic [1:0]                    rsp_resp,
    output logic                          busy,
    output logic [IDX_W-1:0]              grant_id,
    output logic [ADDR_WIDTH-1:0]         M_AXI_AWADDR,
    output logic [2:0]                    M_AXI_AWPROT,
    output logic                          M_AXI_AWVALID,
    input  logic                          M_AXI_AWREADY,
    output logic [DATA_WIDTH-1:0]         M_AXI_WDATA,
    output logic [DATA_WIDTH/8-1:0]       M_AXI_WSTRB,
    output logic                          M_AXI_WVALID,
    input  logic                          M_AXI_WREADY,
    input  logic [1:0]                    M_AXI_BRESP,
    input  logic                          M_AXI_BVALID,
    output logic                          M_AXI_BREADY,
    output logic [ADDR_WIDTH-1:0]         M_AXI_ARADDR,
    output logic [2:0]                    M_AXI_ARPROT,
    output logic                          M_AXI_ARVALID,
    input  logic                          M_AXI_ARREADY,
    input  logic [DATA_WIDTH-1:0]         M_AXI_RDATA,
    input  logic [1:0]                    M_AXI_RRESP,
    input  logic                          M_AXI_RVALID,
    output logic                          M_AXI_RREADY
);

    arb_state_e              state_r, state_n;
    logic [IDX_W-1:0]        last_grant_r, grant_id_r, grant_idx_s;
    logic [NUM_REQ-1:0]      grant_oh_s, grant_oh_r, rsp_valid_r;
    logic                    grant_any_s, rr_mode_s, wr_done_s;
    logic [ADDR_WIDTH-1:0]   addr_r;
    logic [DATA_WIDTH-1:0]   wdata_r, rdata_r;
    logic [1:0]              resp_r;
    logic                    busy_r, awvalid_r, wvalid_r, bready_r, arvalid_r, rready_r;

    axil_rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
        .req        (req_valid),
        .last_grant (last_grant_r),
        .grant_oh   (grant_oh_s),
        .grant_idx  (grant_idx_s),
        .grant_any  (grant_any_s),
        .rr_mode    (rr_mode_s)
    );

    // A channel counts as done once its VALID has dropped or it handshakes this cycle.
    assign wr_done_s = (!awvalid_r || M_AXI_AWREADY) && (!wvalid_r || M_AXI_WREADY);

    // State register.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_n;
        end
    end

    // Next-state decode and the same-cycle accept pulse.
    always_comb begin
        state_n   = state_r;
        req_ready = '0;
        case (state_r)
            IDLE: begin
                if (grant_any_s) begin
                    req_ready = grant_oh_s;
                    state_n   = req_we[grant_idx_s] ? WR_REQ : RD_REQ;
                end else begin
                    state_n = IDLE;
                end
            end
            WR_REQ:  state_n = wr_done_s     ? WR_RESP : WR_REQ;
            WR_RESP: state_n = M_AXI_BVALID  ? RESP    : WR_RESP;
            RD_REQ:  state_n = M_AXI_ARREADY ? RD_DATA : RD_REQ;
            RD_DATA: state_n = M_AXI_RVALID  ? RESP    : RD_DATA;
            RESP:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Command latch, AXI channel handshakes and response capture.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            last_grant_r <= IDX_W'(NUM_REQ - 1);
            grant_id_r   <= '0;
            grant_oh_r   <= '0;
            addr_r       <= '0;
            wdata_r      <= '0;
            rdata_r      <= '0;
            resp_r       <= RESP_OKAY;
            rsp_valid_r  <= '0;
            busy_r       <= 1'b0;
            awvalid_r    <= 1'b0;
            wvalid_r     <= 1'b0;
            bready_r     <= 1'b0;
            arvalid_r    <= 1'b0;
            rready_r     <= 1'b0;
        end else begin
            rsp_valid_r <= '0;
            case (state_r)
                IDLE: begin
                    if (grant_any_s) begin
                        grant_id_r <= grant_idx_s;
                        grant_oh_r <= grant_oh_s;
                        addr_r     <= req_addr[int'(grant_idx_s) * ADDR_WIDTH +: ADDR_WIDTH];
                        wdata_r    <= req_wdata[int'(grant_idx_s) * DATA_WIDTH +: DATA_WIDTH];
                        busy_r     <= 1'b1;
                        awvalid_r  <= req_we[grant_idx_s];
                        wvalid_r   <= req_we[grant_idx_s];
                        arvalid_r  <= !req_we[grant_idx_s];
                    end
                end
                WR_REQ: begin
                    if (M_AXI_AWREADY) awvalid_r <= 1'b0;
                    if (M_AXI_WREADY)  wvalid_r  <= 1'b0;
                    if (wr_done_s)     bready_r  <= 1'b1;
                end
                WR_RESP: begin
                    if (M_AXI_BVALID) begin
                        bready_r    <= 1'b0;
                        resp_r      <= M_AXI_BRESP;
                        rdata_r     <= '0;
                        rsp_valid_r <= grant_oh_r;
                    end
                end
                RD_REQ: begin
                    if (M_AXI_ARREADY) begin
                        arvalid_r <= 1'b0;
                        rready_r  <= 1'b1;
                    end
                end
                RD_DATA: begin
                    if (M_AXI_RVALID) begin
                        rready_r    <= 1'b0;
                        rdata_r     <= M_AXI_RDATA;
                        resp_r      <= M_AXI_RRESP;
                        rsp_valid_r <= grant_oh_r;
                    end
                end
                RESP: begin
                    busy_r <= 1'b0;
                    if (rr_mode_s) last_grant_r <= grant_id_r;
                end
                default: busy_r <= 1'b0;
            endcase
        end
    end

    assign rsp_valid     = rsp_valid_r;
    assign rsp_rdata     = rdata_r;
    assign rsp_resp      = resp_r;
    assign busy          = busy_r;
    assign grant_id      = grant_id_r;
    assign M_AXI_AWADDR  = addr_r;
    assign M_AXI_ARADDR  = addr_r;
    assign M_AXI_AWPROT  = AXI_PROT_DEFAULT;
    assign M_AXI_ARPROT  = AXI_PROT_DEFAULT;
    assign M_AXI_AWVALID = awvalid_r;
    assign M_AXI_WDATA   = wdata_r;
    assign M_AXI_WSTRB   = {(DATA_WIDTH/8){1'b1}};
    assign M_AXI_WVALID  = wvalid_r;
    assign M_AXI_BREADY  = bready_r;
    assign M_AXI_ARVALID = arvalid_r;
    assign M_AXI_RREADY  = rready_r;

endmodule

// File: tb/tb_axil_spi_reg_arbiter.sv
// Directed bench for axil_spi_reg_arbiter with a small AXI4-Lite slave model whose ready delays are tunable.
module tb_axil_spi_reg_arbiter;

    localparam int          N    = 4;
    localparam logic [31:0] BASE = 32'h4000_0000;

    logic            ACLK = 1'b0;
    logic            ARESETN;
    logic [N-1:0]    req_valid, req_we, req_ready, rsp_valid;
    logic [N*32-1:0] req_addr, req_wdata;
    logic [31:0]     rsp_rdata;
    logic [1:0]      rsp_resp;
    logic            busy;
    logic [1:0]      grant_id;
    logic [31:0]     M_AXI_AWADDR, M_AXI_WDATA, M_AXI_ARADDR, M_AXI_RDATA;
    logic [2:0]      M_AXI_AWPROT, M_AXI_ARPROT;
    logic [3:0]      M_AXI_WSTRB;
    logic            M_AXI_AWVALID, M_AXI_AWREADY, M_AXI_WVALID, M_AXI_WREADY;
    logic [1:0]      M_AXI_BRESP, M_AXI_RRESP;
    logic            M_AXI_BVALID, M_AXI_BREADY, M_AXI_ARVALID, M_AXI_ARREADY;
    logic            M_AXI_RVALID, M_AXI_RREADY;

    int checks, failures;

    always #5 ACLK = ~ACLK;

    axil_spi_reg_arbiter #(.NUM_REQ(N), .ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .ACLK(ACLK), .ARESETN(ARESETN),
        .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
        .busy(busy), .grant_id(grant_id),
        .M_AXI_AWADDR(M_AXI_AWADDR), .M_AXI_AWPROT(M_AXI_AWPROT), .M_AXI_AWVALID(M_AXI_AWVALID),
        .M_AXI_AWREADY(M_AXI_AWREADY), .M_AXI_WDATA(M_AXI_WDATA), .M_AXI_WSTRB(M_AXI_WSTRB),
        .M_AXI_WVALID(M_AXI_WVALID), .M_AXI_WREADY(M_AXI_WREADY), .M_AXI_BRESP(M_AXI_BRESP),
        .M_AXI_BVALID(M_AXI_BVALID), .M_AXI_BREADY(M_AXI_BREADY), .M_AXI_ARADDR(M_AXI_ARADDR),
        .M_AXI_ARPROT(M_AXI_ARPROT), .M_AXI_ARVALID(M_AXI_ARVALID), .M_AXI_ARREADY(M_AXI_ARREADY),
        .M_AXI_RDATA(M_AXI_RDATA), .M_AXI_RRESP(M_AXI_RRESP), .M_AXI_RVALID(M_AXI_RVALID),
        .M_AXI_RREADY(M_AXI_RREADY)
    );

    // Slave model: READY rises once VALID has waited *_dly cycles; B/R follow one cycle after the handshakes.
    int          aw_dly = 1, w_dly = 1, aw_cnt, w_cnt, ar_cnt;
    bit          hold_b = 1'b0;
    logic        aw_got, w_got;
    logic [31:0] aw_addr_q, w_data_q;
    logic [31:0] mem [0:15];
    logic        aw_hs, w_hs;

    assign M_AXI_AWREADY = M_AXI_AWVALID && (aw_cnt >= aw_dly);
    assign M_AXI_WREADY  = M_AXI_WVALID  && (w_cnt  >= w_dly);
    assign M_AXI_ARREADY = M_AXI_ARVALID && (ar_cnt >= 1);
    assign M_AXI_BRESP   = 2'b00;
    assign aw_hs         = M_AXI_AWVALID && M_AXI_AWREADY;
    assign w_hs          = M_AXI_WVALID  && M_AXI_WREADY;

    always @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            aw_cnt <= 0; w_cnt <= 0; ar_cnt <= 0;
            aw_got <= 1'b0; w_got <= 1'b0; aw_addr_q <= '0; w_data_q <= '0;
            M_AXI_BVALID <= 1'b0; M_AXI_RVALID <= 1'b0; M_AXI_RDATA <= '0; M_AXI_RRESP <= 2'b00;
            for (int i = 0; i < 16; i++) mem[i] <= '0;
        end else begin
            aw_cnt <= (M_AXI_AWVALID && !M_AXI_AWREADY) ? aw_cnt + 1 : 0;
            w_cnt  <= (M_AXI_WVALID  && !M_AXI_WREADY)  ? w_cnt  + 1 : 0;
            ar_cnt <= (M_AXI_ARVALID && !M_AXI_ARREADY) ? ar_cnt + 1 : 0;
            if (aw_hs) begin aw_got <= 1'b1; aw_addr_q <= M_AXI_AWADDR; end
            if (w_hs)  begin w_got  <= 1'b1; w_data_q  <= M_AXI_WDATA;  end
            if (!M_AXI_BVALID && !hold_b && (aw_got || aw_hs) && (w_got || w_hs)) begin
                M_AXI_BVALID <= 1'b1;
                mem[aw_hs ? M_AXI_AWADDR[5:2] : aw_addr_q[5:2]] <= w_hs ? M_AXI_WDATA : w_data_q;
                aw_got <= 1'b0;
                w_got  <= 1'b0;
            end
            if (M_AXI_BVALID && M_AXI_BREADY) M_AXI_BVALID <= 1'b0;
            if (M_AXI_ARVALID && M_AXI_ARREADY) begin
                M_AXI_RVALID <= 1'b1;
                M_AXI_RRESP  <= (M_AXI_ARADDR == BASE + 32'h10) ? 2'b10 : 2'b00;
                M_AXI_RDATA  <= (M_AXI_ARADDR == BASE + 32'h10) ? 32'h0 : mem[M_AXI_ARADDR[5:2]];
            end
            if (M_AXI_RVALID && M_AXI_RREADY) M_AXI_RVALID <= 1'b0;
        end
    end

    // Protocol monitors, kept as running totals so the test compares deltas.
    int aw_hs_tot, w_hs_tot, bready_early_tot, rsp_tot;
    always @(posedge ACLK) begin
        if (aw_hs) aw_hs_tot <= aw_hs_tot + 1;
        if (w_hs)  w_hs_tot  <= w_hs_tot + 1;
        if (M_AXI_BREADY && (M_AXI_AWVALID || M_AXI_WVALID)) bready_early_tot <= bready_early_tot + 1;
    end
    always @(negedge ACLK) if (rsp_valid != '0) rsp_tot <= rsp_tot + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
        chk({tag, "_axi_valid_ready"}, {27'd0, M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY,
            M_AXI_ARVALID, M_AXI_RREADY}, 32'd0);
        chk({tag, "_req_ready"}, {28'd0, req_ready}, 32'd0);
        chk({tag, "_rsp_valid"}, {28'd0, rsp_valid}, 32'd0);
        chk({tag, "_grant_id"}, {30'd0, grant_id}, 32'd0);
        chk({tag, "_rsp_rdata"}, rsp_rdata, 32'd0);
        chk({tag, "_rsp_resp"}, {30'd0, rsp_resp}, 32'd0);
        chk({tag, "_awaddr"}, M_AXI_AWADDR, 32'd0);
        chk({tag, "_wdata"}, M_AXI_WDATA, 32'd0);
    endtask

    task automatic set_cmd(input int id, input logic we, input logic [31:0] addr, input logic [31:0] data);
        req_we[id]             = we;
        req_addr[id*32 +: 32]  = addr;
        req_wdata[id*32 +: 32] = data;
    endtask

    // One command from an idle arbiter; lat counts cycles from the first req_valid cycle to rsp_valid.
    task automatic do_txn(input int id, input logic we, input logic [31:0] addr, input logic [31:0] data,
                          output int lat, output logic [3:0] mask, output logic [31:0] rd,
                          output logic [1:0] rr, output logic [1:0] gid);
        bit got;
        got = 1'b0; lat = -1; mask = '0; rd = '0; rr = '0; gid = '0;
        set_cmd(id, we, addr, data);
        @(posedge ACLK); #1;
        req_valid[id] = 1'b1;
        for (int k = 0; k < 60; k++) begin
            @(negedge ACLK);
            if (rsp_valid != '0) begin
                lat = k; mask = rsp_valid; rd = rsp_rdata; rr = rsp_resp; gid = grant_id;
                break;
            end
            if (req_ready[id]) got = 1'b1;
            @(posedge ACLK); #1;
            if (got) req_valid[id] = 1'b0;
        end
        req_valid[id] = 1'b0;
    endtask

    // Several requesters at once; those in keep re-request after each grant. Records grant order.
    int grant_q[$];
    task automatic run_group(input logic [3:0] start, input logic [3:0] keep, input int n);
        logic [3:0] rdy;
        grant_q.delete();
        @(posedge ACLK); #1;
        req_valid = start;
        for (int k = 0; k < 300 && grant_q.size() < n; k++) begin
            @(negedge ACLK);
            rdy = req_ready;
            @(posedge ACLK); #1;
            for (int i = 0; i < N; i++) begin
                if (rdy[i]) begin
                    grant_q.push_back(i);
                    if (!keep[i]) req_valid[i] = 1'b0;
                end
            end
        end
        req_valid = '0;
        for (int k = 0; k < 50; k++) begin
            @(negedge ACLK);
            if (!busy) break;
        end
        chk("group_drain_busy", {31'd0, busy}, 32'd0);
    endtask

    task automatic check_grants(input string tag, input int exp []);
        chk({tag, "_count"}, grant_q.size(), exp.size());
        for (int i = 0; i < exp.size() && i < grant_q.size(); i++)
            chk($sformatf("%s_grant%0d", tag, i), grant_q[i], exp[i]);
    endtask

    typedef struct {
        int          id;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic [1:0]  exp_resp;
        int          exp_lat;
    } vec_t;

    initial begin
        vec_t        vecs [7];
        int          lat, a0, w0, e0, r0;
        logic [3:0]  mask;
        logic [31:0] rd;
        logic [1:0]  rr, gid;
        int          exp_all4 [];
        int          exp_after_rst [];
        int          exp_pair [];

        vecs[0] = '{0, 1'b1, BASE + 32'h0,  32'h0101FFFF, 32'h0,        2'b00, 4};
        vecs[1] = '{1, 1'b0, BASE + 32'h0,  32'h0,        32'h0101FFFF, 2'b00, 4};
        vecs[2] = '{2, 1'b1, BASE + 32'h10, 32'h12345678, 32'h0,        2'b00, 4};
        vecs[3] = '{3, 1'b0, BASE + 32'h10, 32'h0,        32'h0,        2'b10, 4};
        vecs[4] = '{0, 1'b0, BASE + 32'h0,  32'h0,        32'h0101FFFF, 2'b00, 4};
        vecs[5] = '{1, 1'b1, BASE + 32'h8,  32'hCAFEF00D, 32'h0,        2'b00, 4};
        vecs[6] = '{3, 1'b0, BASE + 32'h8,  32'h0,        32'hCAFEF00D, 2'b00, 4};
`ifdef AXIL_SPI_ARB_FIXED_PRIO_EN
        exp_all4 = '{0, 0, 0, 0, 0};
        exp_pair = '{1, 1, 1, 1};
`else
        exp_all4 = '{0, 1, 2, 3, 0};
        exp_pair = '{1, 3, 1, 3};
`endif
        exp_after_rst = '{0, 3};

        ARESETN = 1'b0; req_valid = '0; req_we = '0; req_addr = '0; req_wdata = '0;
        #2;
        check_reset_outputs("reset");
        chk("wstrb", {28'd0, M_AXI_WSTRB}, 32'h0000000F);
        chk("prot", {26'd0, M_AXI_AWPROT, M_AXI_ARPROT}, 32'd0);
        repeat (2) @(negedge ACLK);
        ARESETN = 1'b1;

        foreach (vecs[v]) begin
            do_txn(vecs[v].id, vecs[v].we, vecs[v].addr, vecs[v].wdata, lat, mask, rd, rr, gid);
            chk($sformatf("vec%0d_latency", v), lat, vecs[v].exp_lat);
            chk($sformatf("vec%0d_rsp_valid", v), {28'd0, mask}, 32'd1 << vecs[v].id);
            chk($sformatf("vec%0d_rdata", v), rd, vecs[v].exp_rdata);
            chk($sformatf("vec%0d_resp", v), {30'd0, rr}, {30'd0, vecs[v].exp_resp});
            chk($sformatf("vec%0d_grant_id", v), {30'd0, gid}, vecs[v].id);
        end

        // All four write the same register; requester 0 immediately asks again.
        set_cmd(0, 1'b1, BASE + 32'h4, 32'habcd0001);
        set_cmd(1, 1'b1, BASE + 32'h4, 32'hdead0011);
        set_cmd(2, 1'b1, BASE + 32'h4, 32'hbeef0011);
        set_cmd(3, 1'b1, BASE + 32'h4, 32'h0101FFFF);
        run_group(4'b1111, 4'b0001, 5);
        check_grants("all4", exp_all4);
        do_txn(1, 1'b0, BASE + 32'h4, 32'h0, lat, mask, rd, rr, gid);
        chk("all4_final_data", rd, 32'habcd0001);

        // Write with W late, then with AW late.
        a0 = aw_hs_tot; w0 = w_hs_tot; e0 = bready_early_tot;
        aw_dly = 1; w_dly = 4;
        do_txn(2, 1'b1, BASE + 32'hC, 32'h55AA55AA, lat, mask, rd, rr, gid);
        chk("wlate_latency", lat, 7);
        chk("wlate_rsp_valid", {28'd0, mask}, 32'h4);
        aw_dly = 3; w_dly = 1;
        do_txn(2, 1'b1, BASE + 32'hC, 32'h33CC33CC, lat, mask, rd, rr, gid);
        chk("awlate_latency", lat, 6);
        aw_dly = 1; w_dly = 1;
        chk("delay_aw_handshakes", aw_hs_tot - a0, 2);
        chk("delay_w_handshakes", w_hs_tot - w0, 2);
        chk("delay_bready_early", bready_early_tot - e0, 0);
        do_txn(2, 1'b0, BASE + 32'hC, 32'h0, lat, mask, rd, rr, gid);
        chk("delay_readback", rd, 32'h33CC33CC);
        chk("delay_readback_latency", lat, 4);

        // Reset while parked in WR_RESP.
        hold_b = 1'b1;
        set_cmd(2, 1'b1, BASE + 32'h14, 32'h77777777);
        @(posedge ACLK); #1;
        req_valid[2] = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(negedge ACLK);
            if (req_ready[2]) break;
        end
        @(posedge ACLK); #1;
        req_valid = '0;
        for (int k = 0; k < 20; k++) begin
            @(negedge ACLK);
            if (M_AXI_BREADY) break;
        end
        chk("abort_reached_wr_resp", {31'd0, M_AXI_BREADY}, 32'd1);
        r0 = rsp_tot;
        #2 ARESETN = 1'b0;
        #1 check_reset_outputs("abort");
        repeat (3) @(negedge ACLK);
        hold_b  = 1'b0;
        ARESETN = 1'b1;
        repeat (3) @(negedge ACLK);
        chk("abort_no_rsp", rsp_tot - r0, 0);

        set_cmd(0, 1'b0, BASE + 32'h0, 32'h0);
        set_cmd(3, 1'b0, BASE + 32'h0, 32'h0);
        run_group(4'b1001, 4'b0000, 2);
        check_grants("after_reset", exp_after_rst);

        set_cmd(1, 1'b0, BASE + 32'h0, 32'h0);
        run_group(4'b1010, 4'b1010, 4);
        check_grants("pair13", exp_pair);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog");
    end

endmodule
